// File: rtl/alu_sequencer_if.sv
// Command/response handshake bundle for alu_sequencer.
// master drives commands and accepts responses; slave is the sequencer.
interface alu_sequencer_if;
  logic        cmdValid;
  logic        cmdReady;
  logic [15:0] cmdInput1;
  logic [15:0] cmdInput2;
  logic [3:0]  cmdOpcode;
  logic        respValid;
  logic        respReady;
  logic [31:0] respResult;
  logic [2:0]  respError;

  modport master (
    output cmdValid, cmdInput1, cmdInput2, cmdOpcode,
    output respReady,
    input  cmdReady, respValid, respResult, respError
  );

  modport slave (
    input  cmdValid, cmdInput1, cmdInput2, cmdOpcode,
    input  respReady,
    output cmdReady, respValid, respResult, respError
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one command at a time through an external combinational ALU.
// Ports: clk, rst_n, bus (cmd/resp handshake), alu* operands/results, counters.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_sequencer_if.slave bus,
  output logic [15:0] aluInput1,
  output logic [15:0] aluInput2,
  output logic [3:0]  aluOpcode,
  input  logic [31:0] aluResult,
  input  logic [1:0]  aluError,
  output logic [15:0] opCount,
  output logic [15:0] errCount
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be 1..15");
  end

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic        rv_q, rv_d;
  logic [31:0] rr_q, rr_d;
  logic [2:0]  re_q, re_d;
  logic [15:0] opc_q, opc_d;
  logic [15:0] errc_q, errc_d;

  logic cmd_ready;
  logic accept;
  logic op_ok;

  // Gate with rst_n so cmdReady is low for the whole reset window.
  assign cmd_ready = (state_q == S_IDLE) && rst_n;
  assign accept    = bus.cmdValid && cmd_ready;
  assign op_ok     = (op_q >= 4'd1) && (op_q <= 4'd5);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rv_d    = rv_q;
    rr_d    = rr_q;
    re_d    = re_q;
    opc_d   = opc_q;
    errc_d  = errc_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = bus.cmdInput1;
          b_d     = bus.cmdInput2;
          op_d    = bus.cmdOpcode;
          cnt_d   = SETTLE_INIT;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rv_d    = 1'b1;
          state_d = S_RESP;
          if (op_ok) begin
            rr_d = aluResult;
            re_d = {1'b0, aluError};
          end else begin
            rr_d = '0;
            re_d = 3'b100;
          end
        end
      end
      S_RESP: begin
        if (bus.respReady) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
          opc_d   = opc_q + 16'd1;
          if (re_q != 3'b000 && errc_q != 16'hFFFF)
            errc_d = errc_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rv_q    <= 1'b0;
      rr_q    <= '0;
      re_q    <= '0;
      opc_q   <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rv_q    <= rv_d;
      rr_q    <= rr_d;
      re_q    <= re_d;
      opc_q   <= opc_d;
      errc_q  <= errc_d;
    end
  end

  assign bus.cmdReady   = cmd_ready;
  assign bus.respValid  = rv_q;
  assign bus.respResult = rr_q;
  assign bus.respError  = re_q;
  assign aluInput1      = a_q;
  assign aluInput2      = b_q;
  assign aluOpcode      = op_q;
  assign opCount        = opc_q;
  assign errCount       = errc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU attached.
// Table-driven vectors, scoreboard queue, and hand-written corner sequences.
module tb_alu_sequencer;

  localparam int SETTLE = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] aluInput1, aluInput2;
  logic [3:0]  aluOpcode;
  logic [31:0] aluResult;
  logic [1:0]  aluError;
  logic [15:0] opCount, errCount;

  alu_sequencer_if bus ();

  alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .aluInput1 (aluInput1),
    .aluInput2 (aluInput2),
    .aluOpcode (aluOpcode),
    .aluResult (aluResult),
    .aluError  (aluError),
    .opCount   (opCount),
    .errCount  (errCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; invalid codes return junk the sequencer must mask.
  always_comb begin
    aluResult = '0;
    aluError  = '0;
    case (aluOpcode)
      4'd1: aluResult = 32'(aluInput1) + 32'(aluInput2);
      4'd2: begin
        aluResult = {16'h0, aluInput1 - aluInput2};
        aluError  = {1'b0, aluInput1 < aluInput2};
      end
      4'd3: aluResult = 32'(aluInput1) * 32'(aluInput2);
      4'd4: begin
        if (aluInput2 == 0) aluError = 2'b10;
        else aluResult = 32'(aluInput1 / aluInput2);
      end
      4'd5: begin
        if (aluInput2 == 0) aluError = 2'b10;
        else aluResult = 32'(aluInput1 % aluInput2);
      end
      default: begin
        aluResult = 32'hDEADBEEF;
        aluError  = 2'b11;
      end
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic [2:0]  err;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  err;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  exp_t cur;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_ops = 0;
  logic [15:0] exp_errs = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] er,
                       input logic [2:0] ee);
    exp_t e;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(bus.cmdReady), 32'd1);
    bus.cmdValid  = 1'b1;
    bus.cmdInput1 = a;
    bus.cmdInput2 = b;
    bus.cmdOpcode = op;
    e.res = er;
    e.err = ee;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.cmdValid  = 1'b0;
    bus.cmdInput1 = 16'($urandom);
    bus.cmdInput2 = 16'($urandom);
    bus.cmdOpcode = 4'($urandom);
    chk("alu_in1", 32'(aluInput1), 32'(a));
    chk("alu_in2", 32'(aluInput2), 32'(b));
    chk("alu_op", 32'(aluOpcode), 32'(op));
  endtask

  // Returns at the negedge after the first edge showing respValid.
  task automatic wait_resp();
    int lat;
    bit got;
    got = 0;
    lat = 0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.respValid) begin
        lat = i;
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=none required=respValid");
    end else begin
      chk("latency", 32'(lat), 32'(SETTLE));
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty actual=empty required=entry");
    end else begin
      cur = sb.pop_front();
      chk("resp_result", bus.respResult, cur.res);
      chk("resp_error", 32'(bus.respError), 32'(cur.err));
    end
  endtask

  task automatic model_hs();
    exp_ops = exp_ops + 16'd1;
    if (cur.err != 0 && exp_errs != 16'hFFFF)
      exp_errs = exp_errs + 16'd1;
  endtask

  task automatic finish_resp();
    bus.respReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.respReady = 1'b0;
    model_hs();
    chk("hs_valid_low", 32'(bus.respValid), 32'd0);
    chk("hs_cmd_ready", 32'(bus.cmdReady), 32'd1);
    chk("op_count", 32'(opCount), 32'(exp_ops));
    chk("err_count", 32'(errCount), 32'(exp_errs));
    chk("retain_result", bus.respResult, cur.res);
    chk("retain_error", 32'(bus.respError), 32'(cur.err));
  endtask

  initial begin
    int stale;
    vecs[0]  = '{4'd1, 16'd3, 16'd1, 32'h4, 3'b000};
    vecs[1]  = '{4'd2, 16'd3, 16'd1, 32'h2, 3'b000};
    vecs[2]  = '{4'd4, 16'd7, 16'd0, 32'h0, 3'b010};
    vecs[3]  = '{4'd9, 16'd7, 16'd0, 32'h0, 3'b100};
    vecs[4]  = '{4'd3, 16'd300, 16'd200, 32'hEA60, 3'b000};
    vecs[5]  = '{4'd5, 16'd17, 16'd5, 32'h2, 3'b000};
    vecs[6]  = '{4'd2, 16'd1, 16'd3, 32'hFFFE, 3'b001};
    vecs[7]  = '{4'd1, 16'hFFFF, 16'd1, 32'h10000, 3'b000};
    vecs[8]  = '{4'd5, 16'd5, 16'd0, 32'h0, 3'b010};
    vecs[9]  = '{4'd0, 16'd8, 16'd2, 32'h0, 3'b100};
    vecs[10] = '{4'd4, 16'd100, 16'd7, 32'hE, 3'b000};

    rst_n = 1'b0;
    bus.cmdValid  = 1'b0;
    bus.cmdInput1 = '0;
    bus.cmdInput2 = '0;
    bus.cmdOpcode = '0;
    bus.respReady = 1'b0;
    #12;
    chk("rst_cmd_ready", 32'(bus.cmdReady), 32'd0);
    chk("rst_resp_valid", 32'(bus.respValid), 32'd0);
    chk("rst_op_count", 32'(opCount), 32'd0);
    chk("rst_alu_in1", 32'(aluInput1), 32'd0);
    chk("rst_resp_result", bus.respResult, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", 32'(bus.cmdReady), 32'd1);

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err);
      wait_resp();
      finish_resp();
    end

    // Response held off while a new command is waved at the inputs.
    issue(4'd1, 16'd3, 16'd1, 32'h4, 3'b000);
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      bus.cmdValid  = 1'b1;
      bus.cmdInput1 = 16'd9;
      bus.cmdInput2 = 16'd9;
      bus.cmdOpcode = 4'd1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(bus.respValid), 32'd1);
      chk("hold_result", bus.respResult, 32'h4);
      chk("hold_error", 32'(bus.respError), 32'd0);
      chk("hold_cmd_ready", 32'(bus.cmdReady), 32'd0);
      chk("hold_alu_in1", 32'(aluInput1), 32'd3);
    end
    bus.respReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.respReady = 1'b0;
    model_hs();
    chk("hs_no_accept_valid", 32'(bus.respValid), 32'd0);
    chk("hs_no_accept_in1", 32'(aluInput1), 32'd3);
    chk("hs_no_accept_rdy", 32'(bus.cmdReady), 32'd1);
    chk("hs_op_count", 32'(opCount), 32'(exp_ops));
    sb.push_back('{32'd18, 3'b000});
    @(posedge clk);
    @(negedge clk);
    bus.cmdValid = 1'b0;
    chk("late_accept_in1", 32'(aluInput1), 32'd9);
    wait_resp();
    finish_resp();

    // Reset in the middle of SETTLE abandons the operation.
    @(negedge clk);
    bus.cmdValid  = 1'b1;
    bus.cmdInput1 = 16'd3;
    bus.cmdInput2 = 16'd1;
    bus.cmdOpcode = 4'd1;
    @(posedge clk);
    @(negedge clk);
    bus.cmdValid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.respValid), 32'd0);
    chk("mid_rst_ops", 32'(opCount), 32'd0);
    chk("mid_rst_errs", 32'(errCount), 32'd0);
    chk("mid_rst_ready", 32'(bus.cmdReady), 32'd0);
    chk("mid_rst_in1", 32'(aluInput1), 32'd0);
    exp_ops  = '0;
    exp_errs = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.cmdReady), 32'd1);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.respValid) stale++;
    end
    chk("no_stale_resp", 32'(stale), 32'd0);
    issue(4'd3, 16'd6, 16'd7, 32'd42, 3'b000);
    wait_resp();
    finish_resp();

    // Counter boundaries: opCount wraps, errCount saturates.
    @(negedge clk);
    force dut.opc_q = 16'hFFFF;
    force dut.errc_q = 16'hFFFF;
    #1;
    release dut.opc_q;
    release dut.errc_q;
    exp_ops  = 16'hFFFF;
    exp_errs = 16'hFFFF;
    issue(4'd4, 16'd7, 16'd0, 32'h0, 3'b010);
    wait_resp();
    finish_resp();
    issue(4'd1, 16'd2, 16'd2, 32'h4, 3'b000);
    wait_resp();
    finish_resp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
